// File: rtl/c_operand_arbiter.sv
// Round-robin arbiter sharing one C operand register among four requesters.
// A winner is picked in IDLE, its operand is loaded with a one-cycle clock
// enable (LOAD), then held stable for HOLD_CYCLES cycles (HOLD) before the
// next arbitration. Requests are only looked at while IDLE.
module c_operand_arbiter #(
    parameter int CREG        = 1,
    parameter int HOLD_CYCLES = 2
) (
    input  logic         CLK,
    input  logic         RSTC,
    input  logic [3:0]   req,
    input  logic [191:0] req_data,
    output logic [3:0]   gnt,
    output logic [47:0]  c_out,
    output logic         cec_out,
    output logic         c_valid,
    output logic [1:0]   c_owner,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_INIT     = 4'(HOLD_CYCLES);
    // With a bypassed C register the operand is visible in the LOAD cycle,
    // otherwise one cycle later, after the register has captured it.
    localparam logic       VALID_AT_LOAD = (CREG == 0);

    state_t      state_reg;
    logic [1:0]  ptr_reg;
    logic [3:0]  hold_cnt_reg;
    logic [3:0]  gnt_reg;
    logic [47:0] c_out_reg;
    logic        cec_reg;
    logic        c_valid_reg;
    logic [1:0]  c_owner_reg;

    logic [47:0] slice [4];
    logic        win_found;
    logic [1:0]  win_idx;
    logic [1:0]  cand;

    // Split the packed operand bus into per-requester slices.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slice
            assign slice[gi] = req_data[48*gi +: 48];
        end
    endgenerate

    // Round-robin search starting one past the last winner, wrapping back to it.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_reg;
        cand      = ptr_reg;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_reg + 2'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Arbitration FSM with registered outputs; reset aborts any transaction.
    always_ff @(posedge CLK or posedge RSTC) begin
        if (RSTC) begin
            state_reg    <= IDLE;
            ptr_reg      <= 2'd3;
            hold_cnt_reg <= 4'd0;
            gnt_reg      <= 4'd0;
            c_out_reg    <= 48'd0;
            cec_reg      <= 1'b0;
            c_valid_reg  <= 1'b0;
            c_owner_reg  <= 2'd0;
        end else begin
            gnt_reg     <= 4'd0;
            cec_reg     <= 1'b0;
            c_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        c_out_reg   <= slice[win_idx];
                        c_owner_reg <= win_idx;
                        gnt_reg     <= 4'b0001 << win_idx;
                        cec_reg     <= 1'b1;
                        c_valid_reg <= VALID_AT_LOAD;
                        state_reg   <= LOAD;
                    end
                end
                LOAD: begin
                    ptr_reg      <= c_owner_reg;
                    hold_cnt_reg <= HOLD_INIT;
                    c_valid_reg  <= !VALID_AT_LOAD;
                    state_reg    <= HOLD;
                end
                HOLD: begin
                    if (hold_cnt_reg <= 4'd1) begin
                        hold_cnt_reg <= 4'd0;
                        state_reg    <= IDLE;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_reg;
    assign c_out   = c_out_reg;
    assign cec_out = cec_reg;
    assign c_valid = c_valid_reg;
    assign c_owner = c_owner_reg;
    assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_c_operand_arbiter.sv
// Directed bench for c_operand_arbiter. Three instances share the inputs:
// a = CREG 1 / HOLD 2, b = CREG 0 / HOLD 2, c = CREG 1 / HOLD 3.
module tb_c_operand_arbiter;

    logic         CLK = 1'b0;
    logic         RSTC = 1'b1;
    logic [3:0]   req = 4'd0;
    logic [191:0] req_data = 192'd0;

    logic [3:0]  gnt_a, gnt_b, gnt_c;
    logic [47:0] c_out_a, c_out_b, c_out_c;
    logic        cec_a, cec_b, cec_c;
    logic        cv_a, cv_b, cv_c;
    logic [1:0]  own_a, own_b, own_c;
    logic        busy_a, busy_b, busy_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    c_operand_arbiter #(.CREG(1), .HOLD_CYCLES(2)) dut_a (
        .CLK(CLK), .RSTC(RSTC), .req(req), .req_data(req_data),
        .gnt(gnt_a), .c_out(c_out_a), .cec_out(cec_a), .c_valid(cv_a),
        .c_owner(own_a), .busy(busy_a)
    );
    c_operand_arbiter #(.CREG(0), .HOLD_CYCLES(2)) dut_b (
        .CLK(CLK), .RSTC(RSTC), .req(req), .req_data(req_data),
        .gnt(gnt_b), .c_out(c_out_b), .cec_out(cec_b), .c_valid(cv_b),
        .c_owner(own_b), .busy(busy_b)
    );
    c_operand_arbiter #(.CREG(1), .HOLD_CYCLES(3)) dut_c (
        .CLK(CLK), .RSTC(RSTC), .req(req), .req_data(req_data),
        .gnt(gnt_c), .c_out(c_out_c), .cec_out(cec_c), .c_valid(cv_c),
        .c_owner(own_c), .busy(busy_c)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        req  = 4'd0;
        RSTC = 1'b1;
        tick();
        RSTC = 1'b0;
    endtask

    task automatic test_reset();
        RSTC = 1'b1;
        tick();
        tick();
        n_checks++;
        if (gnt_a !== 4'd0 || cec_a !== 1'b0 || cv_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: gnt=%b cec=%b c_valid=%b, required 0000/0/0", gnt_a, cec_a, cv_a);
        end
        n_checks++;
        if (c_out_a !== 48'd0 || own_a !== 2'd0 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: c_out=%h owner=%0d busy=%b, required 0/0/0", c_out_a, own_a, busy_a);
        end
        RSTC = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_single();
        int busy_cnt_a;
        int busy_cnt_c;
        logic saw_gnt;
        req      = 4'b0001;
        req_data = {144'd0, 48'h0000_0000_ABCD};
        tick();
        n_checks++;
        if (gnt_a !== 4'b0001 || cec_a !== 1'b1 || own_a !== 2'd0) begin
            n_fail++;
            $display("FAIL single_load: gnt=%b cec=%b owner=%0d, required 0001/1/0", gnt_a, cec_a, own_a);
        end
        n_checks++;
        if (c_out_a !== 48'h0000_0000_ABCD || c_out_b !== 48'h0000_0000_ABCD) begin
            n_fail++;
            $display("FAIL single_data: c_out_a=%h c_out_b=%h, required 0000_0000_abcd", c_out_a, c_out_b);
        end
        n_checks++;
        if (cv_a !== 1'b0 || cv_b !== 1'b1) begin
            n_fail++;
            $display("FAIL valid_load: creg1=%b creg0=%b, required 0/1", cv_a, cv_b);
        end
        busy_cnt_a = busy_a ? 1 : 0;
        busy_cnt_c = busy_c ? 1 : 0;
        req = 4'b0000;
        tick();
        n_checks++;
        if (gnt_a !== 4'd0 || cec_a !== 1'b0 || cv_a !== 1'b1 || cv_b !== 1'b0) begin
            n_fail++;
            $display("FAIL single_hold1: gnt=%b cec=%b cv_creg1=%b cv_creg0=%b, required 0000/0/1/0",
                     gnt_a, cec_a, cv_a, cv_b);
        end
        busy_cnt_a += busy_a ? 1 : 0;
        busy_cnt_c += busy_c ? 1 : 0;
        saw_gnt = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            busy_cnt_a += busy_a ? 1 : 0;
            busy_cnt_c += busy_c ? 1 : 0;
            if (gnt_a != 4'd0 || cv_a || cv_b) saw_gnt = 1'b1;
        end
        n_checks++;
        if (busy_cnt_a != 3 || busy_cnt_c != 4) begin
            n_fail++;
            $display("FAIL busy_len: hold2=%0d hold3=%0d, required 3/4", busy_cnt_a, busy_cnt_c);
        end
        n_checks++;
        if (saw_gnt !== 1'b0 || busy_a !== 1'b0 || c_out_a !== 48'h0000_0000_ABCD || own_a !== 2'd0) begin
            n_fail++;
            $display("FAIL idle_keep: extra_pulse=%b busy=%b c_out=%h owner=%0d, required 0/0/abcd/0",
                     saw_gnt, busy_a, c_out_a, own_a);
        end
        $display("test_single done: busy cycles %0d/%0d", busy_cnt_a, busy_cnt_c);
    endtask

    task automatic test_round_robin();
        logic [47:0] exp_c [4];
        int order [5];
        int n_gnt;
        int last_cyc;
        exp_c[0] = 48'hA0A0_0000_0000;
        exp_c[1] = 48'hB1B1_0000_0001;
        exp_c[2] = 48'hC2C2_0000_0002;
        exp_c[3] = 48'hD3D3_0000_0003;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
        do_reset();
        req_data = {exp_c[3], exp_c[2], exp_c[1], exp_c[0]};
        req      = 4'b1111;
        n_gnt    = 0;
        last_cyc = -3;
        for (int cyc = 1; cyc <= 17; cyc++) begin
            tick();
            if (gnt_a != 4'd0) begin
                n_checks++;
                if (n_gnt >= 5 || gnt_a !== (4'b0001 << order[n_gnt]) || c_out_a !== exp_c[order[n_gnt] % 4]) begin
                    n_fail++;
                    $display("FAIL rr_order: grant %0d gnt=%b c_out=%h", n_gnt, gnt_a, c_out_a);
                end
                n_checks++;
                if (cyc - last_cyc != 4) begin
                    n_fail++;
                    $display("FAIL rr_spacing: grant %0d at cycle %0d, previous %0d, required spacing 4",
                             n_gnt, cyc, last_cyc);
                end
                $display("rr grant %0d: cycle %0d gnt=%b", n_gnt, cyc, gnt_a);
                last_cyc = cyc;
                n_gnt++;
            end
        end
        n_checks++;
        if (n_gnt != 5) begin
            n_fail++;
            $display("FAIL rr_count: grants=%0d, required 5", n_gnt);
        end
        req = 4'd0;
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_withdrawn();
        logic saw2;
        do_reset();
        req_data = {48'h0, 48'h0000_2222_2222, 48'h0, 48'h0000_0000_0F0F};
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        req  = 4'b0100;
        saw2 = 1'b0;
        tick();
        if (gnt_a[2] || gnt_b[2] || gnt_c[2]) saw2 = 1'b1;
        req = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (gnt_a[2] || gnt_b[2] || gnt_c[2]) saw2 = 1'b1;
        end
        n_checks++;
        if (saw2 !== 1'b0) begin
            n_fail++;
            $display("FAIL withdrawn_gnt: requester 2 granted, required never");
        end
        n_checks++;
        if (busy_a !== 1'b0 || busy_c !== 1'b0 || own_a !== 2'd0) begin
            n_fail++;
            $display("FAIL withdrawn_idle: busy_a=%b busy_c=%b owner=%0d, required 0/0/0", busy_a, busy_c, own_a);
        end
        $display("test_withdrawn done");
    endtask

    task automatic test_reset_mid();
        logic bad;
        do_reset();
        req_data = {48'h4, 48'h3, 48'h2, 48'h0000_5555_0000};
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        tick();
        RSTC = 1'b1;
        #1;
        n_checks++;
        if (gnt_c !== 4'd0 || cec_c !== 1'b0 || cv_c !== 1'b0 || c_out_c !== 48'd0
            || own_c !== 2'd0 || busy_c !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: gnt=%b cec=%b cv=%b c_out=%h owner=%0d busy=%b, required all zero",
                     gnt_c, cec_c, cv_c, c_out_c, own_c, busy_c);
        end
        tick();
        RSTC = 1'b0;
        bad  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (gnt_c != 4'd0 || cv_c || busy_c) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_quiet: activity after reset with no request");
        end
        req = 4'b1111;
        tick();
        n_checks++;
        if (gnt_c !== 4'b0001 || c_out_c !== 48'h0000_5555_0000) begin
            n_fail++;
            $display("FAIL mid_reset_first: gnt=%b c_out=%h, required 0001/0000_5555_0000", gnt_c, c_out_c);
        end
        req = 4'd0;
        for (int i = 0; i < 6; i++) tick();
        $display("test_reset_mid done");
    endtask

    task automatic test_wrap();
        int n_gnt;
        int exp_cyc;
        do_reset();
        req_data = {48'h0000_1234_5678, 48'h1, 48'h2, 48'h3};
        req = 4'b1000;
        n_gnt = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            tick();
            if (gnt_a != 4'd0) begin
                exp_cyc = 1 + 4 * n_gnt;
                n_checks++;
                if (gnt_a !== 4'b1000 || c_out_a !== 48'h0000_1234_5678 || own_a !== 2'd3 || cyc != exp_cyc) begin
                    n_fail++;
                    $display("FAIL wrap_grant: cycle %0d gnt=%b c_out=%h owner=%0d, required cycle %0d 1000/1234_5678/3",
                             cyc, gnt_a, c_out_a, own_a, exp_cyc);
                end
                $display("wrap grant %0d: cycle %0d gnt=%b", n_gnt, cyc, gnt_a);
                n_gnt++;
            end
        end
        n_checks++;
        if (n_gnt != 3) begin
            n_fail++;
            $display("FAIL wrap_count: grants=%0d, required 3", n_gnt);
        end
        req = 4'd0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_withdrawn();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/c_operand_arbiter.md
C_OPERAND_ARBITER -- requirements
Module: c_operand_arbiter

Interface
REQ-001 SHALL have parameter CREG, default 1: pipeline depth of the downstream C operand register (0 = bypass, 1 = registered).
REQ-002 SHALL have parameter HOLD_CYCLES, default 2, legal range 1..15: cycles the operand is held stable after load before re-arbitration.
REQ-003 SHALL have port CLK, input, 1 bit: clock, all state updates on rising edge.
REQ-004 SHALL have port RSTC, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port req, input, 4 bits: per-requester request for the shared C operand port.
REQ-006 SHALL have port req_data, input, 192 bits: four packed 48-bit operands; requester i uses bits [48*i+47:48*i].
REQ-007 SHALL have port gnt, output, 4 bits: one-hot grant pulse, one cycle per load.
REQ-008 SHALL have port c_out, output, 48 bits: operand driven to the C register data input.
REQ-009 SHALL have port cec_out, output, 1 bit: clock enable driven to the C register.
REQ-010 SHALL have port c_valid, output, 1 bit: one-cycle pulse when the operand is present at the C register output mux.
REQ-011 SHALL have port c_owner, output, 2 bits: index of the requester owning the current operand.
REQ-012 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-013 SHALL implement three states: IDLE, LOAD, HOLD.
REQ-014 In IDLE with req != 0, the block SHALL select a winner round-robin, searching from (ptr+1) mod 4 upward with wrap, and SHALL register the winner index and its 48-bit req_data slice at that edge, entering LOAD.
REQ-015 In IDLE with req == 0, the block SHALL remain in IDLE and keep c_out, c_owner and ptr unchanged.
REQ-016 LOAD SHALL last exactly one cycle: gnt[winner]=1, cec_out=1, c_out = captured data; next state HOLD; ptr <= winner.
REQ-017 In all states other than LOAD, gnt SHALL be 0 and cec_out SHALL be 0.
REQ-018 c_out SHALL always equal the last captured operand, so it is stable from LOAD through HOLD.
REQ-019 c_valid SHALL pulse during the LOAD cycle when CREG=0, and during the first HOLD cycle when CREG=1.
REQ-020 HOLD SHALL last exactly HOLD_CYCLES cycles, counted by a 4-bit down-counter loaded at LOAD; on expiry the next state SHALL be IDLE.
REQ-021 Requests sampled only in IDLE: req changes during LOAD/HOLD SHALL have no effect; a withdrawn request is never granted.
REQ-022 A requester that keeps req high after its grant SHALL be re-granted only after all other active requesters are served (fairness), minimum spacing HOLD_CYCLES+2 cycles between grants.
REQ-023 With a single active requester, consecutive grants to it SHALL be permitted (spacing HOLD_CYCLES+2 cycles).
REQ-024 c_owner SHALL update at the arbitration edge together with the captured data.

Reset
REQ-025 While RSTC=1, the block SHALL immediately force state IDLE, gnt=0, cec_out=0, c_valid=0, c_out=0, c_owner=0, HOLD counter=0 and ptr=3 (so requester 0 has first priority).
REQ-026 Reset asserted mid-LOAD or mid-HOLD SHALL abort the transaction with no grant or c_valid afterwards; first arbitration SHALL occur at the first rising edge after RSTC falls.

Verification
REQ-027 Reset then req=4'b0001, slice0=48'h0000_0000_ABCD -> next cycle gnt=0001, cec_out=1, c_out=48'hABCD; CREG=1: c_valid one cycle later; busy high 1+HOLD_CYCLES cycles.
REQ-028 req=4'b1111 held constant, HOLD_CYCLES=2 -> grants in order 0,1,2,3,0 spaced 4 cycles apart, each gnt exactly one cycle.
REQ-029 CREG=0 vs CREG=1 with same stimulus -> c_valid in LOAD cycle vs first HOLD cycle; c_out identical.
REQ-030 req=4'b0100 raised during HOLD of requester 0 and dropped before IDLE -> requester 2 never granted; block returns to IDLE and stays.
REQ-031 RSTC pulsed during HOLD (HOLD_CYCLES=3) -> outputs zero immediately, no c_valid, ptr=3, next grant with req=1111 goes to requester 0.
REQ-032 req=4'b1000 only, ptr=3 -> wrap search grants requester 3; repeated requests re-grant requester 3 every HOLD_CYCLES+2 cycles.
